cpu_muldiv_ctrl: RTL and testbench
==================================

Name: cpu_muldiv_ctrl

Overview:
- Sequences the multi-cycle multiply/divide resource for MUL and MUL_I instructions, which decode marks as latent. It sits beside the ALU in the p3 stage.
- Accepts an operation from p3 and holds the pipeline via a stall request while the resource runs.
- Presents a 32-bit result for one cycle and then releases the pipeline.
- Owns the iterative divider and the multiplier pipeline counter.

Parameters:
- MUL_CYCLES, 2, number of busy cycles for multiply (1..7).
- XLEN, 32, operand/result width; fixed at 32 in this design.

Ports:
- clock, in, 1, system clock
- reset, in, 1, synchronous active-high reset
- start, in, 1, p3 holds a valid mul/div op (p3_op[5:3]==3'b100)
- op, in, 3, p3_op[2:0]: 000 mul, 100 divs, 101 mods, 110 divu, 111 modu
- src_a, in, 32, operand A (post-bypass)
- src_b, in, 32, operand B (post-bypass or literal)
- kill, in, 1, p4_jump_taken; abandons the current operation
- stall_req, out, 1, hold pipeline (ORed into global stall)
- done, out, 1, result valid this cycle
- result, out, 32, operation result

Behaviour:
- Reset values: state IDLE, stall_req=0, done=0, result=0, counter=0.
- Reset mid-operation: return to IDLE next edge, no done pulse.
- States: IDLE, MUL, DIV, DONE.
- stall_req (combinational): (state==IDLE && start && !kill) || state==MUL || state==DIV.
- IDLE + start + !kill:
  - Latch op, src_a, src_b.
  - mul: go to MUL, counter=MUL_CYCLES-1.
  - div/mod: go to DIV, counter=31.
  - Illegal op codes (001/010/011): treat as mul; decode has already flagged them illegal.
- MUL: decrement counter; at 0 go to DONE with result=low 32 bits of a*b. Product is identical for signed and unsigned operands.
- DIV: one restoring step per cycle on |a| and |b| (magnitudes for signed ops, raw values for unsigned); at counter 0 go to DONE.
- DONE:
  - done=1, stall_req=0; the pipeline advances this cycle.
  - Always go to IDLE next cycle.
  - start is ignored in DONE, because p3 still shows the finishing instruction.
- Divide latency: start in cycle 0, DIV in cycles 1..32, DONE in cycle 33; stall_req high in cycles 0..32.
- Multiply latency: DONE in cycle MUL_CYCLES+1.
- Sign fix-up (signed ops):
  - Quotient is negated when sign(a) != sign(b).
  - Remainder takes the sign of a.
  - Applied when entering DONE.
- Divide by zero:
  - divs/divu: result = 0xFFFFFFFF.
  - mods/modu: result = src_a.
  - Detected at start; jump straight to DONE in cycle 1, skipping DIV.
- Overflow (divs 0x80000000 / -1): quotient 0x80000000, remainder 0; no trap.
- kill:
  - In any state, kill forces IDLE next edge, no done pulse, and suppresses stall_req that cycle.
  - kill in DONE: done still asserted; decode discards the instruction via p4 flush.
- result holds its value outside DONE; consumers use it only when done=1.

Decomposition:
- cpu.vh gains MULOP_MUL, MULOP_DIVS, MULOP_MODS, MULOP_DIVU and MULOP_MODU defines, plus the state encoding defines.
- Sub-module cpu_divider_core:
  - 32-step restoring unsigned divider.
  - Ports: clock, load, step, dividend, divisor, quotient, remainder.
  - The controller handles signs, special cases and sequencing.

Test Plan:
- mul a=7, b=-3 (0xFFFFFFFD) -> done at cycle 3, result 0xFFFFFFEB; stall_req high in cycles 0..2.
- divs a=-100, b=7 -> done at cycle 33, result 0xFFFFFFF2 (-14); mods with the same operands -> 0xFFFFFFFE (-2).
- divu a=0x80000000, b=0 -> done at cycle 1, result 0xFFFFFFFF; modu with the same operands -> 0x80000000.
- divs 0x80000000 / 0xFFFFFFFF -> result 0x80000000; mods -> 0.
- divu 100/3 started, kill asserted at cycle 10 -> stall_req low at cycle 10, IDLE at cycle 11, no done pulse. A new divu 9/2 at cycle 11 -> done at cycle 44, result 4.
- Back-to-back: mul then divu, with start held through DONE -> second op begins only in the IDLE cycle after DONE, and no duplicate operation occurs. Reset asserted at cycle 5 of a divide -> IDLE, stall_req=0, done=0.

Source files
------------

// File: rtl/cpu_muldiv_ctrl_pkg.sv
// rtl/cpu_muldiv_ctrl_pkg.sv - shared op codes, state encoding and helpers for the mul/div controller
// Contents:
//   MULOP_*         p3_op[2:0] encodings of the latent mul/div operations
//   muldiv_state_t  controller states IDLE/MUL/DIV/DONE
//   op_is_div       op selects the divider (any op with bit 2 set)
//   op_is_signed    op is divs/mods
//   op_is_mod       op returns the remainder
//   cond_neg        two's-complement negate when asked
package cpu_muldiv_ctrl_pkg;

    localparam logic [2:0] MULOP_MUL  = 3'b000;
    localparam logic [2:0] MULOP_DIVS = 3'b100;
    localparam logic [2:0] MULOP_MODS = 3'b101;
    localparam logic [2:0] MULOP_DIVU = 3'b110;
    localparam logic [2:0] MULOP_MODU = 3'b111;

    localparam logic [4:0] DIV_STEPS_LAST = 5'd31;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MUL  = 2'd1,
        ST_DIV  = 2'd2,
        ST_DONE = 2'd3
    } muldiv_state_t;

    // Codes 001/010/011 are illegal and fall through to the multiplier.
    function automatic logic op_is_div(input logic [2:0] op);
        return (op == MULOP_DIVS) || (op == MULOP_MODS) ||
               (op == MULOP_DIVU) || (op == MULOP_MODU);
    endfunction

    function automatic logic op_is_signed(input logic [2:0] op);
        return (op == MULOP_DIVS) || (op == MULOP_MODS);
    endfunction

    function automatic logic op_is_mod(input logic [2:0] op);
        return (op == MULOP_MODS) || (op == MULOP_MODU);
    endfunction

    function automatic logic [31:0] cond_neg(input logic [31:0] value, input logic negate);
        return negate ? (~value + 32'd1) : value;
    endfunction

endpackage

// File: rtl/cpu_divider_core.sv
// rtl/cpu_divider_core.sv - 32-step restoring unsigned divider datapath
// Ports:
//   clock      system clock
//   load       capture dividend/divisor and clear the partial remainder
//   step       perform one restoring iteration
//   dividend   unsigned dividend, sampled on load
//   divisor    unsigned divisor, sampled on load (non-zero)
//   quotient   quotient register, final after 32 steps
//   remainder  partial remainder register, final after 32 steps
module cpu_divider_core (
    input  logic        clock,
    input  logic        load,
    input  logic        step,
    input  logic [31:0] dividend,
    input  logic [31:0] divisor,
    output logic [31:0] quotient,
    output logic [31:0] remainder
);

    logic [31:0] rem_q;
    logic [31:0] quo_q;
    logic [31:0] dvs_q;

    logic [32:0] shifted;
    logic [31:0] diff;
    logic        fits;

    // The quotient register doubles as the dividend shift register: each
    // step moves its top bit into the remainder and a quotient bit in below.
    always_comb begin
        shifted = {rem_q, quo_q[31]};
        fits    = shifted >= {1'b0, dvs_q};
        // The remainder stays below the divisor, so the true difference
        // always fits in 32 bits.
        diff    = shifted[31:0] - dvs_q;
    end

    always_ff @(posedge clock) begin
        if (load) begin
            rem_q <= 32'd0;
            quo_q <= dividend;
            dvs_q <= divisor;
        end else if (step) begin
            rem_q <= fits ? diff : shifted[31:0];
            quo_q <= {quo_q[30:0], fits};
        end
    end

    assign quotient  = quo_q;
    assign remainder = rem_q;

endmodule

// File: rtl/cpu_muldiv_ctrl.sv
// rtl/cpu_muldiv_ctrl.sv - p3 sequencer for the multi-cycle multiply/divide resource
// Ports:
//   clock      system clock
//   reset      synchronous active-high reset
//   start      p3 holds a valid mul/div op
//   op         p3_op[2:0]: 000 mul, 100 divs, 101 mods, 110 divu, 111 modu
//   src_a      operand A (post-bypass)
//   src_b      operand B (post-bypass or literal)
//   kill       p4 jump taken; abandons the current operation
//   stall_req  hold the pipeline while the resource is busy
//   done       result valid this cycle
//   result     operation result, meaningful when done is high
module cpu_muldiv_ctrl
    import cpu_muldiv_ctrl_pkg::*;
#(
    parameter int MUL_CYCLES = 2,
    parameter int XLEN       = 32
) (
    input  logic            clock,
    input  logic            reset,
    input  logic            start,
    input  logic [2:0]      op,
    input  logic [XLEN-1:0] src_a,
    input  logic [XLEN-1:0] src_b,
    input  logic            kill,
    output logic            stall_req,
    output logic            done,
    output logic [XLEN-1:0] result
);

    localparam logic [4:0] MUL_LOAD = 5'(MUL_CYCLES - 1);

    muldiv_state_t state, state_n;

    logic [4:0]      counter;
    logic [XLEN-1:0] a_q;
    logic [XLEN-1:0] b_q;
    logic [XLEN-1:0] result_q;
    logic            is_mod_q;
    logic            neg_quo_q;
    logic            neg_rem_q;
    // High when DONE must take its value from the divider core rather than
    // from result_q (multiply and divide-by-zero preload result_q instead).
    logic            div_path_q;

    logic            accept;
    logic            start_div;
    logic            start_signed;
    logic            div_by_zero;
    logic [XLEN-1:0] abs_a;
    logic [XLEN-1:0] abs_b;
    logic [XLEN-1:0] product;
    logic [XLEN-1:0] div_result;
    logic [XLEN-1:0] quotient;
    logic [XLEN-1:0] remainder;
    logic            div_load;
    logic            div_step;

    assign accept       = (state == ST_IDLE) && start && !kill;
    assign start_div    = op_is_div(op);
    assign start_signed = op_is_signed(op);
    assign div_by_zero  = (src_b == '0);
    assign abs_a        = cond_neg(src_a, start_signed && src_a[XLEN-1]);
    assign abs_b        = cond_neg(src_b, start_signed && src_b[XLEN-1]);
    assign product      = a_q * b_q;

    // The last restoring step lands on the same edge that enters DONE, so
    // the sign fix-up is applied to the core outputs during DONE itself.
    assign div_result = is_mod_q ? cond_neg(remainder, neg_rem_q)
                                 : cond_neg(quotient, neg_quo_q);
    assign result     = ((state == ST_DONE) && div_path_q) ? div_result : result_q;

    cpu_divider_core u_divider_core (
        .clock     (clock),
        .load      (div_load),
        .step      (div_step),
        .dividend  (abs_a),
        .divisor   (abs_b),
        .quotient  (quotient),
        .remainder (remainder)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_n;
        end
    end

    always_comb begin
        state_n   = state;
        stall_req = 1'b0;
        done      = 1'b0;
        div_load  = 1'b0;
        div_step  = 1'b0;
        case (state)
            ST_IDLE: begin
                if (start) begin
                    stall_req = 1'b1;
                    if (!start_div) begin
                        state_n = ST_MUL;
                    end else if (div_by_zero) begin
                        state_n = ST_DONE;
                    end else begin
                        state_n  = ST_DIV;
                        div_load = 1'b1;
                    end
                end
            end
            ST_MUL: begin
                stall_req = 1'b1;
                if (counter == 5'd0) begin
                    state_n = ST_DONE;
                end
            end
            ST_DIV: begin
                stall_req = 1'b1;
                div_step  = 1'b1;
                if (counter == 5'd0) begin
                    state_n = ST_DONE;
                end
            end
            ST_DONE: begin
                // start is ignored here: p3 still shows the finishing op.
                done    = 1'b1;
                state_n = ST_IDLE;
            end
            default: begin
                state_n = ST_IDLE;
            end
        endcase
        if (kill) begin
            state_n   = ST_IDLE;
            stall_req = 1'b0;
            div_load  = 1'b0;
            div_step  = 1'b0;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            counter    <= 5'd0;
            a_q        <= '0;
            b_q        <= '0;
            result_q   <= '0;
            is_mod_q   <= 1'b0;
            neg_quo_q  <= 1'b0;
            neg_rem_q  <= 1'b0;
            div_path_q <= 1'b0;
        end else if (accept) begin
            a_q       <= src_a;
            b_q       <= src_b;
            is_mod_q  <= op_is_mod(op);
            neg_quo_q <= start_signed && (src_a[XLEN-1] ^ src_b[XLEN-1]);
            neg_rem_q <= start_signed && src_a[XLEN-1];
            if (!start_div) begin
                counter    <= MUL_LOAD;
                div_path_q <= 1'b0;
            end else if (div_by_zero) begin
                counter    <= 5'd0;
                div_path_q <= 1'b0;
                result_q   <= op_is_mod(op) ? src_a : '1;
            end else begin
                counter    <= DIV_STEPS_LAST;
                div_path_q <= 1'b1;
            end
        end else if (!kill) begin
            case (state)
                ST_MUL: begin
                    if (counter == 5'd0) begin
                        result_q <= product;
                    end else begin
                        counter <= counter - 5'd1;
                    end
                end
                ST_DIV: begin
                    if (counter != 5'd0) begin
                        counter <= counter - 5'd1;
                    end
                end
                ST_DONE: begin
                    // Keep the presented value visible after the pulse.
                    result_q <= result;
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_cpu_muldiv_ctrl.sv
// tb/tb_cpu_muldiv_ctrl.sv - directed self-checking bench for cpu_muldiv_ctrl
module tb_cpu_muldiv_ctrl;
    import cpu_muldiv_ctrl_pkg::*;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic [2:0]  op    = 3'b000;
    logic [31:0] src_a = 32'd0;
    logic [31:0] src_b = 32'd0;
    logic        kill  = 1'b0;
    logic        stall_req;
    logic        done;
    logic [31:0] result;

    int passed = 0;
    int failed = 0;
    int total  = 0;

    cpu_muldiv_ctrl #(.MUL_CYCLES(2), .XLEN(32)) dut (
        .clock     (clock),
        .reset     (reset),
        .start     (start),
        .op        (op),
        .src_a     (src_a),
        .src_b     (src_b),
        .kill      (kill),
        .stall_req (stall_req),
        .done      (done),
        .result    (result)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            failed++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Called just after a falling edge (cycle 0). Drives the op, then
    // follows the operation until done, bounded at 60 cycles.
    task automatic run_op(input string tag, input logic [2:0] o, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] exp_res,
                          input int exp_cyc, input bit hold_start);
        int  cyc;
        bit  seen;
        bit  stall_ok;
        start = 1'b1;
        op    = o;
        src_a = a;
        src_b = b;
        #1;
        stall_ok = stall_req && !done;
        cyc  = 0;
        seen = 1'b0;
        while (!seen && cyc < 60) begin
            @(negedge clock);
            cyc++;
            if (!hold_start) start = 1'b0;
            #1;
            if (done) seen = 1'b1;
            else if (!stall_req) stall_ok = 1'b0;
        end
        check({tag, "_done_cycle"}, 32'(cyc), 32'(exp_cyc));
        check({tag, "_result"}, result, exp_res);
        check({tag, "_stall_in_done"}, {31'd0, stall_req}, 32'd0);
        check({tag, "_stall_while_busy"}, {31'd0, stall_ok}, 32'd1);
    endtask

    initial begin
        bit any_done;

        @(negedge clock);
        @(negedge clock);
        #1;
        check("reset_stall", {31'd0, stall_req}, 32'd0);
        check("reset_done", {31'd0, done}, 32'd0);
        check("reset_result", result, 32'd0);
        reset = 1'b0;

        // Multiply 7 * -3 = -21, done at MUL_CYCLES+1 = 3.
        @(negedge clock);
        run_op("mul", MULOP_MUL, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFEB, 3, 1'b0);

        // Illegal code behaves as a multiply: 0x10000 * 0x10001 low word.
        @(negedge clock);
        run_op("mul_illegal", 3'b001, 32'h0001_0000, 32'h0001_0001, 32'h0001_0000, 3, 1'b0);

        // Signed divide: -100 / 7 = -14 rem -2.
        @(negedge clock);
        run_op("divs", MULOP_DIVS, 32'hFFFF_FF9C, 32'd7, 32'hFFFF_FFF2, 33, 1'b0);
        @(negedge clock);
        run_op("mods", MULOP_MODS, 32'hFFFF_FF9C, 32'd7, 32'hFFFF_FFFE, 33, 1'b0);

        // 100 / -7 = -14 rem 2 (remainder follows the dividend).
        @(negedge clock);
        run_op("divs_negb", MULOP_DIVS, 32'd100, 32'hFFFF_FFF9, 32'hFFFF_FFF2, 33, 1'b0);
        @(negedge clock);
        run_op("mods_negb", MULOP_MODS, 32'd100, 32'hFFFF_FFF9, 32'd2, 33, 1'b0);

        // Divide by zero finishes in cycle 1.
        @(negedge clock);
        run_op("divu_zero", MULOP_DIVU, 32'h8000_0000, 32'd0, 32'hFFFF_FFFF, 1, 1'b0);
        @(negedge clock);
        run_op("modu_zero", MULOP_MODU, 32'h8000_0000, 32'd0, 32'h8000_0000, 1, 1'b0);

        // Signed overflow.
        @(negedge clock);
        run_op("divs_ovf", MULOP_DIVS, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 33, 1'b0);
        @(negedge clock);
        run_op("mods_ovf", MULOP_MODS, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 33, 1'b0);

        // Kill at cycle 10 of divu 100/3.
        @(negedge clock);
        start = 1'b1;
        op    = MULOP_DIVU;
        src_a = 32'd100;
        src_b = 32'd3;
        any_done = 1'b0;
        for (int c = 1; c <= 9; c++) begin
            @(negedge clock);
            start = 1'b0;
            #1;
            if (done) any_done = 1'b1;
        end
        @(negedge clock);
        kill = 1'b1;
        #1;
        check("kill_stall", {31'd0, stall_req}, 32'd0);
        if (done) any_done = 1'b1;
        @(negedge clock);
        kill = 1'b0;
        #1;
        if (done) any_done = 1'b1;
        check("kill_no_done", {31'd0, any_done}, 32'd0);
        check("kill_idle_stall", {31'd0, stall_req}, 32'd0);
        // New divu 9/2 in cycle 11 completes 33 cycles later (cycle 44).
        run_op("divu_after_kill", MULOP_DIVU, 32'd9, 32'd2, 32'd4, 33, 1'b0);

        // Kill during DONE still presents done.
        @(negedge clock);
        start = 1'b1;
        op    = MULOP_MUL;
        src_a = 32'd5;
        src_b = 32'd6;
        @(negedge clock);
        start = 1'b0;
        @(negedge clock);
        @(negedge clock);
        kill = 1'b1;
        #1;
        check("kill_done_pulse", {31'd0, done}, 32'd1);
        check("kill_done_result", result, 32'd30);
        @(negedge clock);
        kill = 1'b0;
        #1;
        check("kill_done_after", {31'd0, done}, 32'd0);

        // Back-to-back with start held through DONE.
        @(negedge clock);
        run_op("b2b_mul", MULOP_MUL, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFEB, 3, 1'b1);
        @(negedge clock);
        run_op("b2b_divu", MULOP_DIVU, 32'd100, 32'd7, 32'd14, 33, 1'b0);
        @(negedge clock);
        #1;
        check("b2b_no_dup_done", {31'd0, done}, 32'd0);
        check("b2b_no_dup_stall", {31'd0, stall_req}, 32'd0);

        // Reset at cycle 5 of a divide.
        @(negedge clock);
        start = 1'b1;
        op    = MULOP_DIVS;
        src_a = 32'd1000;
        src_b = 32'd7;
        for (int c = 1; c <= 4; c++) begin
            @(negedge clock);
            start = 1'b0;
        end
        @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        #1;
        check("rst_mid_stall", {31'd0, stall_req}, 32'd0);
        check("rst_mid_done", {31'd0, done}, 32'd0);
        check("rst_mid_result", result, 32'd0);
        any_done = 1'b0;
        for (int c = 0; c < 40; c++) begin
            @(negedge clock);
            #1;
            if (done || stall_req) any_done = 1'b1;
        end
        check("rst_mid_quiet", {31'd0, any_done}, 32'd0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
